// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path:
// instruction fields, datapath select codes, FSM states and decode classes.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_BB   = 4'b0011;
    localparam logic [3:0] ALU_AA   = 4'b0100;
    localparam logic [3:0] ALU_ADD  = 4'b0101;
    localparam logic [3:0] ALU_LT   = 4'b0110;

    localparam logic [2:0] NPC_PC4    = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_J      = 3'b011;
    localparam logic [2:0] NPC_JR     = 3'b100;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DCD,
        S_EXE_R,
        S_EXE_I,
        S_EXE_A,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BR,
        S_JMP,
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_ILL
    } iclass_e;

    // States that issue a memory request and may stall on mem_ready.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: opcode/funct to instruction class and
// the ALU, immediate-extension and byte-load selects used by the FSM.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output iclass_e    iclass_o,
    output logic [3:0] alu_ctrl_o,
    output logic [1:0] ext_op_o,
    output logic       lb_o
);

    always_comb begin
        iclass_o   = CLS_ILL;
        alu_ctrl_o = ALU_ADDU;
        ext_op_o   = EXT_ZERO;
        lb_o       = (opcode_i == OP_LB);

        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: begin iclass_o = CLS_R;  alu_ctrl_o = ALU_ADDU; end
                    FN_SUBU: begin iclass_o = CLS_R;  alu_ctrl_o = ALU_SUBU; end
                    FN_SLT:  begin iclass_o = CLS_R;  alu_ctrl_o = ALU_LT;   end
                    FN_JR:   begin iclass_o = CLS_JR; alu_ctrl_o = ALU_AA;   end
                    default: iclass_o = CLS_ILL;
                endcase
            end
            OP_ORI: begin
                iclass_o   = CLS_I;
                alu_ctrl_o = ALU_OR;
                ext_op_o   = EXT_ZERO;
            end
            OP_LUI: begin
                iclass_o   = CLS_I;
                alu_ctrl_o = ALU_BB;
                ext_op_o   = EXT_LUI;
            end
            OP_ADDI: begin
                iclass_o   = CLS_I;
                alu_ctrl_o = ALU_ADD;
                ext_op_o   = EXT_SIGN;
            end
            OP_ADDIU: begin
                iclass_o   = CLS_I;
                alu_ctrl_o = ALU_ADDU;
                ext_op_o   = EXT_SIGN;
            end
            OP_LW, OP_LB: begin
                iclass_o   = CLS_LOAD;
                alu_ctrl_o = ALU_ADDU;
                ext_op_o   = EXT_SIGN;
            end
            OP_SW: begin
                iclass_o   = CLS_STORE;
                alu_ctrl_o = ALU_ADDU;
                ext_op_o   = EXT_SIGN;
            end
            OP_BEQ: begin
                iclass_o   = CLS_BEQ;
                alu_ctrl_o = ALU_SUBU;
            end
            OP_J:    iclass_o = CLS_J;
            OP_JAL:  iclass_o = CLS_JAL;
            default: iclass_o = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared memory, with wait-state timeout and retired-instruction count.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             alu_src,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic [2:0]       npc_sel,
    output logic [1:0]       ext_op,
    output logic             lb,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic             bus_err,
    output logic [3:0]       state
);

    localparam int unsigned WAIT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);
    localparam bit TIMEOUT_EN = (MEM_WAIT_MAX != 0);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q;
    logic               illegal_q, bus_err_q;
    logic               mem_wait, timeout, set_illegal;

    iclass_e            dec_class;
    logic [3:0]         dec_alu;
    logic [1:0]         dec_ext;
    logic               dec_lb;

    mc_decode u_decode (
        .opcode_i   (opcode),
        .funct_i    (funct),
        .iclass_o   (dec_class),
        .alu_ctrl_o (dec_alu),
        .ext_op_o   (dec_ext),
        .lb_o       (dec_lb)
    );

    assign mem_wait = is_mem_state(state_q) && !mem_ready;
    assign timeout  = TIMEOUT_EN && mem_wait && (wait_q == WAIT_LIM);

    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;

        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_d = S_DCD;
                else if (timeout) state_d = S_HALT;
            end
            S_DCD: begin
                case (dec_class)
                    CLS_R:                    state_d = S_EXE_R;
                    CLS_I:                    state_d = S_EXE_I;
                    CLS_LOAD, CLS_STORE:      state_d = S_EXE_A;
                    CLS_BEQ:                  state_d = S_BR;
                    CLS_J, CLS_JAL, CLS_JR:   state_d = S_JMP;
                    default: begin
                        state_d     = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_EXE_R, S_EXE_I: state_d = S_WB_ALU;
            S_EXE_A: state_d = (dec_class == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)    state_d = S_WB_MEM;
                else if (timeout) state_d = S_HALT;
            end
            S_MEM_WR: begin
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_HALT;
            end
            S_WB_ALU, S_WB_MEM, S_BR, S_JMP: state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Any state change restarts the wait count, so each new request starts from zero.
        if (state_d != state_q) wait_d = '0;
        else if (mem_wait)      wait_d = wait_q + WAIT_W'(1);
        else                    wait_d = wait_q;
    end

    always_comb begin
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        alu_src    = 1'b0;
        alu_ctrl   = ALU_ADDU;
        reg_dst    = DST_RT;
        wd_sel     = WD_ALU;
        npc_sel    = NPC_PC4;
        ext_op     = EXT_ZERO;
        lb         = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    npc_sel = NPC_PC4;
                end
            end
            S_EXE_R: begin
                alu_src  = 1'b0;
                alu_ctrl = dec_alu;
            end
            S_EXE_I, S_EXE_A: begin
                alu_src  = 1'b1;
                alu_ctrl = dec_alu;
                ext_op   = dec_ext;
            end
            S_MEM_RD: begin
                mem_rd   = 1'b1;
                lb       = dec_lb;
                alu_src  = 1'b1;
                alu_ctrl = dec_alu;
                ext_op   = dec_ext;
            end
            S_MEM_WR: begin
                mem_wr     = 1'b1;
                alu_src    = 1'b1;
                alu_ctrl   = dec_alu;
                ext_op     = dec_ext;
                instr_done = mem_ready;
            end
            S_WB_ALU: begin
                reg_wr     = 1'b1;
                wd_sel     = WD_ALU;
                reg_dst    = (opcode == OP_RTYPE) ? DST_RD : DST_RT;
                instr_done = 1'b1;
            end
            S_WB_MEM: begin
                reg_wr     = 1'b1;
                wd_sel     = WD_MEM;
                reg_dst    = DST_RT;
                lb         = dec_lb;
                instr_done = 1'b1;
            end
            S_BR: begin
                alu_src    = 1'b0;
                alu_ctrl   = ALU_SUBU;
                npc_sel    = NPC_BRANCH;
                pc_wr      = zero;
                instr_done = 1'b1;
            end
            S_JMP: begin
                pc_wr      = 1'b1;
                instr_done = 1'b1;
                case (dec_class)
                    CLS_JAL: begin
                        npc_sel = NPC_JAL;
                        reg_wr  = 1'b1;
                        reg_dst = DST_RA;
                        wd_sel  = WD_PC4;
                    end
                    CLS_JR: begin
                        npc_sel  = NPC_JR;
                        alu_ctrl = ALU_AA;
                    end
                    default: npc_sel = NPC_J;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (instr_done)  retired_q <= retired_q + CNT_W'(1);
            if (set_illegal) illegal_q <= 1'b1;
            if (timeout)     bus_err_q <= 1'b1;
        end
    end

    assign retired = retired_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected outputs are queued with
// the stimulus and compared as the DUT steps through each instruction.
module tb_mc_ctrl;
    import mc_pkg::*;

    localparam int unsigned WAIT_MAX = 3;
    localparam int unsigned CW       = 4;

    localparam logic [5:0] OPC_R   = 6'b000000;
    localparam logic [5:0] OPC_J   = 6'b000010;
    localparam logic [5:0] OPC_JAL = 6'b000011;
    localparam logic [5:0] OPC_BEQ = 6'b000100;
    localparam logic [5:0] OPC_ADI = 6'b001000;
    localparam logic [5:0] OPC_AIU = 6'b001001;
    localparam logic [5:0] OPC_ORI = 6'b001101;
    localparam logic [5:0] OPC_LUI = 6'b001111;
    localparam logic [5:0] OPC_LB  = 6'b100000;
    localparam logic [5:0] OPC_LW  = 6'b100011;
    localparam logic [5:0] OPC_SW  = 6'b101011;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_JR    = 6'b001000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    opcode = '0;
    logic [5:0]    funct = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, alu_src, lb, instr_done, illegal, bus_err;
    logic [3:0]    alu_ctrl, state;
    logic [1:0]    reg_dst, wd_sel, ext_op;
    logic [2:0]    npc_sel;
    logic [CW-1:0] retired;

    mc_ctrl #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
        .reg_dst(reg_dst), .wd_sel(wd_sel), .npc_sel(npc_sel), .ext_op(ext_op),
        .lb(lb), .instr_done(instr_done), .retired(retired), .illegal(illegal),
        .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    st;
        logic          pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, alu_src;
        logic [3:0]    alu_ctrl;
        logic [1:0]    reg_dst, wd_sel;
        logic [2:0]    npc_sel;
        logic [1:0]    ext_op;
        logic          lb, instr_done, illegal, bus_err;
        logic [CW-1:0] retired;
    } outv_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       z;
    } stim_t;

    stim_t         stim_q[$];
    outv_t         exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] exp_ret;
    logic          exp_ill, exp_berr;

    function automatic outv_t base(input state_e s);
        outv_t e = '0;
        e.st      = s;
        e.retired = exp_ret;
        e.illegal = exp_ill;
        e.bus_err = exp_berr;
        return e;
    endfunction

    function automatic stim_t mk(input logic [5:0] op, input logic [5:0] fn, input logic r, input logic z);
        stim_t s;
        s.op = op; s.fn = fn; s.rdy = r; s.z = z;
        return s;
    endfunction

    function automatic outv_t sample();
        outv_t a;
        a.st = state; a.pc_wr = pc_wr; a.ir_wr = ir_wr; a.reg_wr = reg_wr;
        a.mem_rd = mem_rd; a.mem_wr = mem_wr; a.alu_src = alu_src; a.alu_ctrl = alu_ctrl;
        a.reg_dst = reg_dst; a.wd_sel = wd_sel; a.npc_sel = npc_sel; a.ext_op = ext_op;
        a.lb = lb; a.instr_done = instr_done; a.illegal = illegal; a.bus_err = bus_err;
        a.retired = retired;
        return a;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(1));
    endfunction

    task automatic push(input stim_t s, input outv_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
        stim_q.delete(); exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_ret  = '0;
        exp_ill  = 1'b0;
        exp_berr = 1'b0;
    endtask

    task automatic gen_fetch(input logic [5:0] op, input logic [5:0] fn, input int unsigned waits, input logic z);
        outv_t e;
        for (int unsigned i = 0; i < waits; i++) begin
            e = base(S_FETCH); e.mem_rd = 1'b1;
            push(mk(op, fn, 1'b0, z), e);
        end
        e = base(S_FETCH); e.mem_rd = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1; e.npc_sel = 3'b000;
        push(mk(op, fn, 1'b1, z), e);
        e = base(S_DCD);
        push(mk(op, fn, rnd(), z), e);
    endtask

    task automatic gen_alu(input logic [5:0] op, input logic [5:0] fn, input logic rtype,
                           input logic [3:0] ac, input logic [1:0] ext, input int unsigned fwaits);
        outv_t e;
        gen_fetch(op, fn, fwaits, 1'b0);
        e = base(rtype ? S_EXE_R : S_EXE_I);
        e.alu_src = !rtype; e.alu_ctrl = ac; e.ext_op = rtype ? 2'b00 : ext;
        push(mk(op, fn, rnd(), 1'b0), e);
        e = base(S_WB_ALU);
        e.reg_wr = 1'b1; e.wd_sel = 2'b00; e.reg_dst = rtype ? 2'b01 : 2'b00; e.instr_done = 1'b1;
        push(mk(op, fn, rnd(), 1'b0), e);
        exp_ret++;
    endtask

    task automatic gen_load(input logic [5:0] op, input int unsigned waits);
        outv_t e;
        logic  is_lb = (op == OPC_LB);
        gen_fetch(op, 6'h15, 0, 1'b0);
        e = base(S_EXE_A); e.alu_src = 1'b1; e.alu_ctrl = 4'b0000; e.ext_op = 2'b01;
        push(mk(op, 6'h15, rnd(), 1'b0), e);
        for (int unsigned i = 0; i <= waits; i++) begin
            e = base(S_MEM_RD); e.mem_rd = 1'b1; e.lb = is_lb;
            e.alu_src = 1'b1; e.alu_ctrl = 4'b0000; e.ext_op = 2'b01;
            push(mk(op, 6'h15, (i == waits), 1'b0), e);
        end
        e = base(S_WB_MEM); e.reg_wr = 1'b1; e.wd_sel = 2'b01; e.reg_dst = 2'b00;
        e.lb = is_lb; e.instr_done = 1'b1;
        push(mk(op, 6'h15, rnd(), 1'b0), e);
        exp_ret++;
    endtask

    task automatic gen_store(input int unsigned waits);
        outv_t e;
        gen_fetch(OPC_SW, 6'h2a, 0, 1'b0);
        e = base(S_EXE_A); e.alu_src = 1'b1; e.alu_ctrl = 4'b0000; e.ext_op = 2'b01;
        push(mk(OPC_SW, 6'h2a, rnd(), 1'b0), e);
        for (int unsigned i = 0; i <= waits; i++) begin
            e = base(S_MEM_WR); e.mem_wr = 1'b1;
            e.alu_src = 1'b1; e.alu_ctrl = 4'b0000; e.ext_op = 2'b01;
            e.instr_done = (i == waits);
            push(mk(OPC_SW, 6'h2a, (i == waits), 1'b0), e);
        end
        exp_ret++;
    endtask

    task automatic gen_beq(input logic z);
        outv_t e;
        gen_fetch(OPC_BEQ, 6'h00, 0, z);
        e = base(S_BR); e.alu_src = 1'b0; e.alu_ctrl = 4'b0001; e.npc_sel = 3'b001;
        e.pc_wr = z; e.instr_done = 1'b1;
        push(mk(OPC_BEQ, 6'h00, rnd(), z), e);
        exp_ret++;
    endtask

    task automatic gen_jump(input logic [5:0] op, input logic [5:0] fn);
        outv_t e;
        gen_fetch(op, fn, 0, 1'b0);
        e = base(S_JMP); e.pc_wr = 1'b1; e.instr_done = 1'b1;
        if (op == OPC_JAL) begin
            e.npc_sel = 3'b010; e.reg_wr = 1'b1; e.reg_dst = 2'b10; e.wd_sel = 2'b10;
        end else if (op == OPC_J) begin
            e.npc_sel = 3'b011;
        end else begin
            e.npc_sel = 3'b100; e.alu_ctrl = 4'b0100;
        end
        push(mk(op, fn, rnd(), 1'b0), e);
        exp_ret++;
    endtask

    task automatic gen_tail();
        outv_t e;
        e = base(S_FETCH); e.mem_rd = 1'b1;
        push(mk(6'h00, 6'h00, 1'b0, 1'b0), e);
    endtask

    task automatic test_reset();
        outv_t a, e;
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = OPC_JAL;
        exp_ret = '0; exp_ill = 1'b0; exp_berr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = sample(); e = base(S_IDLE); n_checks++;
        if (a !== e) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", a, e); end
        @(negedge clk); rst_n = 1'b1; #1;
        a = sample(); n_checks++;
        if (a !== e) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", a, e); end
        @(negedge clk); mem_ready = 1'b0; #1;
        a = sample(); e = base(S_FETCH); e.mem_rd = 1'b1; n_checks++;
        if (a !== e) begin n_fail++; $display("FAIL reset_fetch: got %h expected %h", a, e); end
    endtask

    task automatic test_alu_ops();
        stim_t s; outv_t e, a; int k = 0;
        do_reset();
        gen_alu(OPC_R,   F_ADDU, 1'b1, 4'b0000, 2'b00, 0);
        gen_alu(OPC_R,   F_SUBU, 1'b1, 4'b0001, 2'b00, 0);
        gen_alu(OPC_R,   F_SLT,  1'b1, 4'b0110, 2'b00, 1);
        gen_alu(OPC_ORI, 6'h3f,  1'b0, 4'b0010, 2'b00, 0);
        gen_alu(OPC_LUI, 6'h00,  1'b0, 4'b0011, 2'b10, 0);
        gen_alu(OPC_ADI, 6'h11,  1'b0, 4'b0101, 2'b01, 0);
        gen_alu(OPC_AIU, 6'h22,  1'b0, 4'b0000, 2'b01, 0);
        gen_tail();
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z; #1;
            a = sample(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL alu_ops step %0d: got %h expected %h", k, a, e); end
            k++;
        end
    endtask

    task automatic test_memory();
        stim_t s; outv_t e, a; int k = 0;
        do_reset();
        gen_load(OPC_LW, 2);
        gen_load(OPC_LB, 2);
        gen_load(OPC_LW, WAIT_MAX);
        gen_store(0);
        gen_store(WAIT_MAX);
        gen_tail();
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z; #1;
            a = sample(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL memory step %0d: got %h expected %h", k, a, e); end
            k++;
        end
    endtask

    task automatic test_branch_jump();
        stim_t s; outv_t e, a; int k = 0;
        do_reset();
        gen_beq(1'b0);
        gen_beq(1'b1);
        gen_jump(OPC_JAL, 6'h00);
        gen_jump(OPC_R, F_JR);
        gen_jump(OPC_J, 6'h00);
        gen_tail();
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z; #1;
            a = sample(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL branch_jump step %0d: got %h expected %h", k, a, e); end
            k++;
        end
    endtask

    task automatic test_illegal();
        stim_t s; outv_t e, a; int k = 0;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            // Unknown opcode first, then a known opcode with an unsupported funct.
            if (pass == 0) gen_fetch(6'b111111, 6'h00, 0, 1'b0);
            else           gen_fetch(OPC_R, 6'b100000, 0, 1'b0);
            exp_ill = 1'b1;
            for (int i = 0; i < 20; i++) begin
                e = base(S_HALT);
                push(mk(s.op, 6'h00, rnd(), rnd()), e);
                stim_q[stim_q.size()-1].op = stim_q[0].op;
                stim_q[stim_q.size()-1].fn = stim_q[0].fn;
            end
            while (exp_q.size() != 0) begin
                s = stim_q.pop_front(); e = exp_q.pop_front();
                @(negedge clk); opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z; #1;
                a = sample(); n_checks++;
                if (a !== e) begin n_fail++; $display("FAIL illegal step %0d: got %h expected %h", k, a, e); end
                k++;
            end
        end
    endtask

    task automatic test_timeout();
        stim_t s; outv_t e, a; int k = 0;
        for (int pass = 0; pass < 3; pass++) begin
            do_reset();
            if (pass == 0) begin
                for (int unsigned i = 0; i <= WAIT_MAX; i++) begin
                    e = base(S_FETCH); e.mem_rd = 1'b1;
                    push(mk(OPC_R, F_ADDU, 1'b0, 1'b0), e);
                end
            end else if (pass == 1) begin
                gen_store(0);
                exp_ret = '0;
                stim_q.delete(); exp_q.delete();
                gen_fetch(OPC_SW, 6'h00, 0, 1'b0);
                e = base(S_EXE_A); e.alu_src = 1'b1; e.ext_op = 2'b01;
                push(mk(OPC_SW, 6'h00, 1'b1, 1'b0), e);
                for (int unsigned i = 0; i <= WAIT_MAX; i++) begin
                    e = base(S_MEM_WR); e.mem_wr = 1'b1; e.alu_src = 1'b1; e.ext_op = 2'b01;
                    push(mk(OPC_SW, 6'h00, 1'b0, 1'b0), e);
                end
            end else begin
                gen_alu(OPC_R, F_ADDU, 1'b1, 4'b0000, 2'b00, WAIT_MAX);
                gen_tail();
            end
            if (pass != 2) begin
                exp_berr = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    e = base(S_HALT);
                    push(mk(6'h00, 6'h00, rnd(), 1'b0), e);
                end
            end
            while (exp_q.size() != 0) begin
                s = stim_q.pop_front(); e = exp_q.pop_front();
                @(negedge clk); opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z; #1;
                a = sample(); n_checks++;
                if (a !== e) begin n_fail++; $display("FAIL timeout pass %0d step %0d: got %h expected %h", pass, k, a, e); end
                k++;
            end
        end
    endtask

    task automatic test_reset_mid_write();
        stim_t s; outv_t e, a; int k = 0;
        do_reset();
        gen_alu(OPC_R, F_ADDU, 1'b1, 4'b0000, 2'b00, 0);
        gen_fetch(OPC_SW, 6'h00, 0, 1'b0);
        e = base(S_EXE_A); e.alu_src = 1'b1; e.ext_op = 2'b01;
        push(mk(OPC_SW, 6'h00, 1'b0, 1'b0), e);
        e = base(S_MEM_WR); e.mem_wr = 1'b1; e.alu_src = 1'b1; e.ext_op = 2'b01;
        push(mk(OPC_SW, 6'h00, 1'b0, 1'b0), e);
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z; #1;
            a = sample(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL mid_write step %0d: got %h expected %h", k, a, e); end
            k++;
        end
        #1 rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        exp_ret = '0;
        a = sample(); e = base(S_IDLE); n_checks++;
        if (a !== e) begin n_fail++; $display("FAIL mid_write_async: got %h expected %h", a, e); end
        @(negedge clk); rst_n = 1'b1; #1;
        a = sample(); n_checks++;
        if (a !== e) begin n_fail++; $display("FAIL mid_write_idle: got %h expected %h", a, e); end
        @(negedge clk); #1;
        a = sample(); e = base(S_FETCH); e.mem_rd = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1; n_checks++;
        if (a !== e) begin n_fail++; $display("FAIL mid_write_fetch: got %h expected %h", a, e); end
    endtask

    task automatic test_back_to_back();
        stim_t s; outv_t e, a; int k = 0;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            case (i % 5)
                0: gen_alu(OPC_R, F_ADDU, 1'b1, 4'b0000, 2'b00, 0);
                1: gen_alu(OPC_ORI, 6'h01, 1'b0, 4'b0010, 2'b00, 0);
                2: gen_load(OPC_LW, 0);
                3: gen_beq(1'b1);
                default: gen_jump(OPC_J, 6'h00);
            endcase
        end
        gen_tail();
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            @(negedge clk); opcode = s.op; funct = s.fn; mem_ready = s.rdy; zero = s.z; #1;
            a = sample(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL back_to_back step %0d: got %h expected %h", k, a, e); end
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_ops();
        test_memory();
        test_branch_jump();
        test_illegal();
        test_timeout();
        test_reset_mid_write();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS-subset datapath. Replaces single-cycle decode with per-state strobes over one shared instruction/data memory.
- Sequences fetch, decode, execute, memory and writeback per instruction, and inserts wait states on the memory handshake.
- Detects illegal instructions and memory timeouts, and counts retired instructions.
- Sits between the IR/ALU-zero outputs and the PC, IR, register-file, ALU and memory enables.

Parameters:
- MEM_WAIT_MAX, 15: max wait cycles on mem_ready before bus error; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], stable from DCD until the instruction retires
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_wr  out  1  PC load enable
- ir_wr  out  1  IR load enable
- reg_wr  out  1  register-file write
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- alu_src  out  1  0 = rt, 1 = extended immediate
- alu_ctrl  out  4  Addu 0000, Subu 0001, Or 0010, Bb 0011, Aa 0100, Add 0101, Lt 0110
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- wd_sel  out  2  00 ALU, 01 memory, 10 PC+4
- npc_sel  out  3  000 PC+4, 001 branch, 010 jal, 011 j, 100 jr
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 lui
- lb  out  1  byte-load select
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- retired  out  CNT_W  count of completed instructions
- illegal  out  1  sticky: unsupported instruction decoded
- bus_err  out  1  sticky: memory timeout
- state  out  4  current state, for debug

Behaviour:
- Reset: state = IDLE; illegal, bus_err and retired = 0. All strobes are 0 in IDLE. IDLE moves to FETCH on the next clk.
- All outputs are a function of state, registered IR fields, zero and mem_ready. Non-listed strobes are 0 in every state.
- FETCH:
  - mem_rd = 1.
  - When mem_ready = 1: ir_wr = 1, pc_wr = 1, npc_sel = 000; go to DCD.
  - Otherwise stay in FETCH.
- DCD: strobes 0. Next state by class:
  - addu / subu / slt -> EXE_R
  - ori / lui / addi / addiu -> EXE_I
  - lw / lb / sw -> EXE_A
  - beq -> BR
  - j / jal / jr -> JMP
  - anything else -> HALT, with illegal set.
- EXE_R: alu_src = 0; alu_ctrl from funct. Go to WB_ALU.
- EXE_I: alu_src = 1; alu_ctrl Or / Bb / Add / Addu; ext_op 00 / 10 / 01 / 01. Go to WB_ALU.
- EXE_A: alu_src = 1, alu_ctrl = Addu, ext_op = 01. Go to MEM_RD (lw, lb) or MEM_WR (sw).
- MEM_RD:
  - mem_rd = 1, lb = (opcode == lb). EXE_A ALU controls are held.
  - mem_ready = 1 -> WB_MEM.
- MEM_WR:
  - mem_wr = 1. EXE_A ALU controls are held.
  - mem_ready = 1 -> FETCH with instr_done = 1.
- WB_ALU: reg_wr = 1, wd_sel = 00, reg_dst = 01 (R-type) or 00 (I-type). Go to FETCH with instr_done = 1.
- WB_MEM: reg_wr = 1, wd_sel = 01, reg_dst = 00, lb held. Go to FETCH with instr_done = 1.
- BR:
  - alu_src = 0, alu_ctrl = Subu, npc_sel = 001.
  - pc_wr = zero (same cycle); the branch offset is applied to the already-incremented PC.
  - Go to FETCH with instr_done = 1.
- JMP:
  - pc_wr = 1; npc_sel 011 (j), 010 (jal), 100 (jr).
  - jr additionally drives alu_ctrl = Aa.
  - jal additionally drives reg_wr = 1, reg_dst = 10, wd_sel = 10.
  - Go to FETCH with instr_done = 1.
- HALT: all strobes 0 and state held until reset; illegal or bus_err stays 1.
- Timeout:
  - A wait counter clears on entry to FETCH, MEM_RD or MEM_WR and increments each cycle with mem_ready = 0.
  - If mem_ready is still 0 when the counter equals MEM_WAIT_MAX (MEM_WAIT_MAX > 0), the next state is HALT and bus_err is set. No strobe fires in that cycle beyond the request.
  - mem_ready = 1 in the same cycle as the limit counts as success.
- retired increments on every instr_done and wraps modulo 2^CNT_W.
- rst_n low in any state (e.g. mid MEM_WR) clears all strobes immediately, asynchronously; no partial writeback is allowed.
- mem_ready in non-memory states is ignored.

Decomposition:
- Package mc_pkg holds:
  - opcode/funct constants
  - alu_ctrl codes
  - npc_sel, reg_dst, wd_sel and ext_op encodings
  - state enum: IDLE, FETCH, DCD, EXE_R, EXE_I, EXE_A, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BR, JMP, HALT
- One combinational sub-module, mc_decode: opcode/funct -> instruction class, alu_ctrl, ext_op, lb. The FSM, wait counter and retired counter stay in mc_ctrl.

Test Plan:
- addu (000000/100001), mem_ready tied 1 -> FETCH, DCD, EXE_R, WB_ALU. reg_wr = 1 with reg_dst = 01 only in cycle 4; instr_done once; retired = 1.
- lw (100011) with mem_ready held low for 2 cycles in MEM_RD -> mem_rd high for 3 cycles, then WB_MEM with wd_sel = 01 and reg_wr = 1. lb (100000) identical but with lb = 1.
- beq (000100) with zero = 0, then with zero = 1 -> pc_wr = 0 in the first BR, then pc_wr = 1 with npc_sel = 001.
- jal (000011) -> JMP with pc_wr = 1, npc_sel = 010, reg_wr = 1, reg_dst = 10, wd_sel = 10. jr (000000/001000) -> npc_sel = 100, alu_ctrl = 0100, reg_wr = 0.
- opcode 111111 -> HALT after DCD; illegal = 1; no strobes for 20 cycles. mem_ready stuck 0 in FETCH with MEM_WAIT_MAX = 3 -> HALT with bus_err = 1 after 4 FETCH cycles.
- rst_n asserted mid MEM_WR -> mem_wr = 0 immediately and retired = 0. After release: IDLE then FETCH; flags cleared.
